conv_ctrl: RTL
==============

# conv_ctrl

Sequencer for the 2-D convolution accelerator. It runs a valid-mode convolution of a SIZE×SIZE unsigned image with a SIZE_KERNEL×SIZE_KERNEL unsigned kernel. The image and kernel are read from the block's 1-cycle-latency image and kernel buffers (the buffers the AXI-full slave fills), and each result is written to the result buffer. Start, ready and done are exposed to the AXI-lite register bank.

## Interface

**Parameters**
- WIDTH, 8: pixel and kernel coefficient width, unsigned.
- SIZE, 10: image side length.
- SIZE_KERNEL, 5: kernel side length.
- OUT_SIZE, SIZE-SIZE_KERNEL+1 (6): result side length.
- IADDR_W, 7: image address width, ≥ clog2(SIZE*SIZE).
- KADDR_W, 5: kernel address width, ≥ clog2(SIZE_KERNEL²).
- OADDR_W, 6: result address width, ≥ clog2(OUT_SIZE²).
- ACC_W, 2*WIDTH+5 (21): accumulator and result width.

**Ports**
- s00_axi_aclk, in, 1: the single clock.
- s00_axi_areset, in, 1: asynchronous, active-high reset.
- start, in, 1: run request; sampled only in IDLE.
- ready, out, 1: high in IDLE only.
- done, out, 1: one-cycle completion pulse.
- rd_en, out, 1: read strobe to the image and kernel buffers.
- img_addr, out, IADDR_W: image read address.
- krn_addr, out, KADDR_W: kernel read address.
- img_data, in, WIDTH: image data, valid one cycle after rd_en.
- krn_data, in, WIDTH: kernel data, valid one cycle after rd_en.
- res_we, out, 1: result write enable.
- res_addr, out, OADDR_W: result address.
- res_data, out, ACC_W: result value.

## Operation

**States:** IDLE, FETCH, DRAIN, WRITE, DONE.

**IDLE**
- ready=1.
- start=1 → FETCH. Pixel counters r,c cleared, tap counters kr,kc cleared, acc cleared.

**FETCH** (SIZE_KERNEL² cycles per output pixel)
- rd_en=1.
- img_addr = (r+kr)*SIZE + (c+kc).
- krn_addr = kr*SIZE_KERNEL + kc.
- kc increments fastest; kc wraps at SIZE_KERNEL and increments kr.
- After tap (SIZE_KERNEL-1, SIZE_KERNEL-1) → DRAIN.

**Accumulate:** in every cycle following a rd_en cycle, acc += img_data*krn_data. This is a full-width unsigned product added into ACC_W bits.

**DRAIN** (1 cycle)
- rd_en=0.
- Last product is accumulated.
- → WRITE.

**WRITE** (1 cycle)
- res_we=1, res_addr = r*OUT_SIZE + c, res_data = acc.
- acc cleared at the end of this cycle.
- c increments; c wraps at OUT_SIZE and increments r.
- If the pixel just written is (OUT_SIZE-1, OUT_SIZE-1) → DONE; else → FETCH.

**DONE** (1 cycle)
- done=1.
- → IDLE.

**Rules**
- start outside IDLE is ignored; there is no queuing.
- Holding start high continuously starts a new run each time IDLE is entered.
- Arithmetic is unsigned. ACC_W cannot overflow: the maximum is 25·255·255 = 1,625,625 < 2²¹.
- res_data, res_addr, img_addr and krn_addr are don't-care when their strobe is low, but are driven to 0 in IDLE.

## Timing

- **Reset values:** state=IDLE, ready=1, done=0, rd_en=0, res_we=0, all addresses 0, res_data=0, acc=0, all counters 0.
- **Reset mid-run:** takes effect immediately and asynchronously. No further rd_en or res_we is issued. A partial run is discarded and not resumed.
- **Start to first read:** start sampled in cycle 0 → first rd_en in cycle 1.
- **Per output pixel:** SIZE_KERNEL²+2 = 27 cycles (25 FETCH, 1 DRAIN, 1 WRITE).
- **First result:** res_we in cycle 27.
- **Last result:** res_we in cycle 36·27 = 972.
- **Completion:** done pulses in cycle 973, and ready=1 again from cycle 974.
- **Buffer latency:** exactly 1 cycle. The block never issues rd_en back-to-back across a pixel boundary without a DRAIN/WRITE gap.
- All outputs are registered or decoded directly from registered state. There is no combinational path from img_data or krn_data to any output except through acc.

## Test plan

1. **All ones.** Reset; image all 1, kernel all 1; pulse start.
   - Expect 36 writes, res_addr 0..35 in order, each res_data=25.
   - Expect done exactly at cycle 973 and ready=1 at cycle 974.
2. **Overflow bound.** Image all 255, kernel all 255.
   - Every res_data=1,625,625; no wrap.
3. **Centre-delta kernel.** img[i]=i; kernel krn[12]=1, others 0.
   - res_data = (r+2)*10+(c+2).
   - res_addr 0 → 22, res_addr 5 → 27, res_addr 35 → 77.
4. **Address sequence.** Run from start; check the first 25 rd_en cycles.
   - img_addr = 0,1,2,3,4,10,…,44.
   - krn_addr = 0..24.
   - Second pixel begins at img_addr 1.
   - Last pixel's final img_addr = 99.
5. **Start handling.** Hold start high for 2000 cycles.
   - Exactly two complete runs (36 writes each), separated by one IDLE cycle.
   - Pulses of start mid-run have no effect.
6. **Reset mid-run.** Assert s00_axi_areset at cycle 300.
   - Outputs return to reset values the same cycle, with no res_we afterwards.
   - After release, a new start yields a full correct run with the scenario-1 results.

Source files
------------

// File: rtl/conv_ctrl.sv
// conv_ctrl -- sequencer for the 2-D valid-mode convolution accelerator.
//
// Walks every output pixel (r, c) of an OUT_SIZE x OUT_SIZE result. For each
// pixel it reads SIZE_KERNEL^2 image/kernel pairs from the 1-cycle-latency
// buffers, accumulates their products, and writes the sum to the result
// buffer.
//
// Ports:
//   s00_axi_aclk    clock
//   s00_axi_areset  asynchronous active-high reset
//   start           run request, sampled only while idle
//   ready           high while idle
//   done            one-cycle pulse after the last result write
//   rd_en           read strobe to the image and kernel buffers
//   img_addr        image read address
//   krn_addr        kernel read address
//   img_data        image data, valid the cycle after rd_en
//   krn_data        kernel data, valid the cycle after rd_en
//   res_we          result write enable
//   res_addr        result address
//   res_data        result value (accumulator)
module conv_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SIZE        = 10,
  parameter int SIZE_KERNEL = 5,
  parameter int OUT_SIZE    = SIZE - SIZE_KERNEL + 1,
  parameter int IADDR_W     = 7,
  parameter int KADDR_W     = 5,
  parameter int OADDR_W     = 6,
  parameter int ACC_W       = 2 * WIDTH + 5
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_areset,
  input  logic               start,
  output logic               ready,
  output logic               done,
  output logic               rd_en,
  output logic [IADDR_W-1:0] img_addr,
  output logic [KADDR_W-1:0] krn_addr,
  input  logic [WIDTH-1:0]   img_data,
  input  logic [WIDTH-1:0]   krn_data,
  output logic               res_we,
  output logic [OADDR_W-1:0] res_addr,
  output logic [ACC_W-1:0]   res_data
);

  localparam int KC_W = (SIZE_KERNEL > 1) ? $clog2(SIZE_KERNEL) : 1;
  localparam int OC_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [KC_W-1:0] K_LAST = KC_W'(SIZE_KERNEL - 1);
  localparam logic [OC_W-1:0] O_LAST = OC_W'(OUT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [OC_W-1:0]   r_q, r_d, c_q, c_d;
  logic [KC_W-1:0]   kr_q, kr_d, kc_q, kc_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  // Marks the cycle in which buffer data answering a rd_en is present.
  logic              valid_q, valid_d;
  logic [2*WIDTH-1:0] prod;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (kc_q == K_LAST && kr_q == K_LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (c_q == O_LAST && r_q == O_LAST) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters and accumulator
  // ---------------------------------------------------------------------
  assign prod = img_data * krn_data;

  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    acc_d   = acc_q;
    valid_d = (state_q == S_FETCH);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d  = '0;
          c_d  = '0;
          kr_d = '0;
          kc_d = '0;
        end
      end
      S_FETCH: begin
        // kc is the fast index; the final tap wraps both back to zero so
        // the next pixel starts clean.
        if (kc_q == K_LAST) begin
          kc_d = '0;
          kr_d = (kr_q == K_LAST) ? '0 : kr_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (c_q == O_LAST) begin
          c_d = '0;
          r_d = (r_q == O_LAST) ? '0 : r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Clearing on WRITE leaves acc at zero for the next pixel and for IDLE;
    // the start clear covers anything left by an interrupted run.
    if (state_q == S_WRITE || (state_q == S_IDLE && start)) begin
      acc_d = '0;
    end else if (valid_q) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // ---------------------------------------------------------------------
  // Output decode (from registered state only)
  // ---------------------------------------------------------------------
  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    res_we   = 1'b0;
    img_addr = '0;
    krn_addr = '0;
    res_addr = '0;
    res_data = '0;
    unique case (state_q)
      S_IDLE:  ready = 1'b1;
      S_FETCH: begin
        rd_en    = 1'b1;
        img_addr = IADDR_W'((32'(r_q) + 32'(kr_q)) * SIZE + 32'(c_q) + 32'(kc_q));
        krn_addr = KADDR_W'(32'(kr_q) * SIZE_KERNEL + 32'(kc_q));
      end
      S_WRITE: begin
        res_we   = 1'b1;
        res_addr = OADDR_W'(32'(r_q) * OUT_SIZE + 32'(c_q));
        res_data = acc_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
